// File: rtl/acumulador_saturado.sv
// acumulador_saturado: sums TAPS signed products, rescales by FRAC with floor and saturates to N bits
module acumulador_saturado #(
  parameter int N     = 25,
  parameter int FRAC  = 20,
  parameter int TAPS  = 4,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [2*N-1:0]   Multip,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [N-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_flag,
  output logic [$clog2(TAPS):0]   tap_count
);
  localparam int ACC_W = 2*N+GUARD;
  localparam int CW = $clog2(TAPS)+1;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(N-1)-1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
  localparam logic [CW-1:0] LAST = CW'(TAPS-1);

  if (TAPS < 1 || TAPS > 2**GUARD) begin : g_bad_taps
    $error("acumulador_saturado: TAPS must be in 1..2**GUARD");
  end

  typedef enum logic {ACUM, SALIDA} state_t;
  state_t state_q;
  logic signed [ACC_W-1:0] acc_q, sum_d, scaled;
  logic [CW-1:0] cnt_q;
  logic signed [N-1:0] data_q, data_d;
  logic sat_q, sat_d, sat_hi, sat_lo;

  // next sum with the guard-extended product, then floor rescale and clip
  always_comb begin
    sum_d  = acc_q + {{GUARD{Multip[2*N-1]}}, Multip};
    scaled = sum_d >>> FRAC;
    sat_hi = scaled > MAXV;
    sat_lo = scaled < MINV;
    sat_d  = sat_hi | sat_lo;
    data_d = sat_hi ? MAXV[N-1:0] : sat_lo ? MINV[N-1:0] : scaled[N-1:0];
  end

  // group FSM: accumulate TAPS products, then hold the result until it is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else if (state_q == ACUM) begin
      if (in_valid) begin
        if (cnt_q == LAST) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          data_q  <= data_d;
          sat_q   <= sat_d;
          state_q <= SALIDA;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end else if (out_ready) begin
      state_q <= ACUM;
    end
  end

  assign in_ready  = state_q == ACUM;
  assign out_valid = state_q == SALIDA;
  assign out_data  = data_q;
  assign sat_flag  = sat_q;
  assign tap_count = cnt_q;
endmodule

// File: tb/tb_acumulador_saturado.sv
// tb_acumulador_saturado: directed vectors with hand-computed results for acumulador_saturado
module tb_acumulador_saturado;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic signed [49:0] Multip = '0;
  logic in_ready, out_valid, sat_flag;
  logic [24:0] out_data;
  logic [2:0] tap_count;
  int errs = 0, checks = 0;
  logic signed [49:0] one = 50'sd1;
  logic [24:0] held;

  acumulador_saturado dut (
    .clk(clk), .reset(reset), .Multip(Multip), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .tap_count(tap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [49:0] p);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1;
    Multip = p;
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  task automatic group(input string tag, input logic signed [49:0] p0, input logic signed [49:0] p,
                       input logic [24:0] exp_d, input logic exp_s);
    send(p0);
    for (int i = 1; i < 4; i++) send(p);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_sat"}, sat_flag, exp_s);
    chk({tag, "_tap0"}, tap_count, 0);
    drain();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tap", tap_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", sat_flag, 0);
    reset = 0;

    send(one <<< 40);
    send(one <<< 40);
    chk("pre_rst_tap", tap_count, 2);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_tap", tap_count, 0);
    group("fresh", one <<< 40, one <<< 40, 25'h0400000, 0);

    group("neg", -(one <<< 40), -(one <<< 40), 25'h1C00000, 0);
    group("floor_pos", one, one, 25'h0000000, 0);
    group("floor_neg", -one, -one, 25'h1FFFFFF, 0);
    group("sat_pos", one <<< 46, one <<< 46, 25'h0FFFFFF, 1);
    group("sat_neg", -(one <<< 46), -(one <<< 46), 25'h1000000, 1);
    group("edge_max", ((one <<< 24) - one) <<< 20, '0, 25'h0FFFFFF, 0);
    group("edge_min", -(one <<< 44), '0, 25'h1000000, 0);

    for (int i = 0; i < 4; i++) send(one <<< 40);
    chk("bp_valid", out_valid, 1);
    held = out_data;
    in_valid = 1;
    Multip = one <<< 46;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_tap", tap_count, 0);
      chk("bp_valid_hold", out_valid, 1);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_tap", tap_count, 0);
    in_valid = 0;
    tick();
    chk("bp_idle_tap", tap_count, 0);

    for (int i = 0; i < 4; i++) begin
      send(one <<< 40);
      chk("gap_tap", tap_count, 3'((i + 1) % 4));
      tick();
      chk("gap_hold_tap", tap_count, 3'((i + 1) % 4));
    end
    chk("gap_valid", out_valid, 1);
    chk("gap_data", out_data, 25'h0400000);
    chk("gap_sat", sat_flag, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
